// File: rtl/instr_encoder.sv
// -----------------------------------------------------------------------------
// instr_encoder
//
// Packs decoded RISC-V instruction fields (R- and I-format) into 32-bit words,
// buffers them in a small FIFO, and writes them sequentially into instruction
// memory starting at word 0. Used to build programs for the single-cycle CPU.
//
// Parameters
//   DEPTH   FIFO entries (power of two, >= 2)
//   ADDR_W  instruction-memory word-address width (capacity 2^ADDR_W words)
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   clear_i      synchronous flush of FIFO, address and count
//   req_valid_i  field request valid
//   req_ready_o  request can be accepted this cycle (independent of valid)
//   fmt_i        0 = R-format, 1 = I-format
//   funct7_i     R-format funct7
//   funct3_i     funct3
//   rd_i         destination register
//   rs1_i        source register 1
//   rs2_i        source register 2 (R-format only)
//   imm_i        12-bit immediate (I-format only)
//   mem_we_o     write request to instruction memory
//   mem_addr_o   word address of the current write
//   mem_data_o   encoded instruction word
//   mem_ack_i    memory accepts the current write
//   count_o      words committed to memory
//   full_o       memory capacity exhausted
// -----------------------------------------------------------------------------
module instr_encoder #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              fmt_i,
  input  logic [6:0]        funct7_i,
  input  logic [2:0]        funct3_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        rs1_i,
  input  logic [4:0]        rs2_i,
  input  logic [11:0]       imm_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  input  logic              mem_ack_i,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned CNT_W = ADDR_W + 1;
  // Wide enough that count + occupancy can never overflow, whatever the
  // relation between DEPTH and the memory capacity.
  localparam int unsigned RES_W = ((ADDR_W > PTR_W) ? ADDR_W : PTR_W) + 2;

  localparam logic [6:0]       OPC_R   = 7'b0110011;
  localparam logic [6:0]       OPC_I   = 7'b0010011;
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);
  localparam logic [CNT_W-1:0] CAP     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [RES_W-1:0] RES_CAP = RES_W'(CAP);

  // State
  logic [31:0]      r_fifo [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic [CNT_W-1:0] r_count;

  // Combinational
  logic [31:0]      w_word;
  logic             w_push;
  logic             w_pop;
  logic [RES_W-1:0] w_reserved;
  logic [OCC_W-1:0] w_occ_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;

  // Field packing
  always_comb begin
    w_word = '0;
    if (fmt_i) begin
      w_word = {imm_i, rs1_i, funct3_i, rd_i, OPC_I};
    end else begin
      w_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OPC_R};
    end
  end

  // Every word buffered or committed holds a memory slot, so the memory can
  // never be oversubscribed and no write is ever issued past the last word.
  always_comb begin
    w_reserved  = RES_W'(r_count) + RES_W'(r_occ);
    req_ready_o = !clear_i && (r_occ < OCC_MAX) && (w_reserved < RES_CAP);
  end

  // Write port
  always_comb begin
    mem_we_o   = (r_occ != '0);
    mem_addr_o = r_count[ADDR_W-1:0];
    mem_data_o = r_fifo[r_rd_ptr];
    count_o    = r_count;
    full_o     = (r_count == CAP);
  end

  // Handshakes; clear_i suppresses both push (through req_ready_o) and commit.
  always_comb begin
    w_push = req_valid_i && req_ready_o;
    w_pop  = mem_we_o && mem_ack_i && !clear_i;
  end

  // Next-state
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    w_count_nxt  = r_count;
    w_occ_nxt    = r_occ;
    if (clear_i) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
      w_occ_nxt    = '0;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
        w_count_nxt  = r_count + CNT_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   w_occ_nxt = r_occ + OCC_W'(1);
        2'b01:   w_occ_nxt = r_occ - OCC_W'(1);
        default: w_occ_nxt = r_occ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_occ    <= w_occ_nxt;
      r_count  <= w_count_nxt;
    end
  end

  // Storage needs no reset: it is only observable through the pointers.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_word;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
module tb_instr_encoder;

  localparam int unsigned DEPTH    = 4;
  localparam int unsigned ADDR_W   = 8;
  localparam int unsigned C_ADDR_W = 2;
  localparam int          CAP      = 1 << ADDR_W;
  localparam int          C_CAP    = 1 << C_ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Main instance (DEPTH=4, ADDR_W=8)
  logic              d_clear, d_valid, d_ready, d_fmt, d_we, d_ack, d_full;
  logic [6:0]        d_funct7;
  logic [2:0]        d_funct3;
  logic [4:0]        d_rd, d_rs1, d_rs2;
  logic [11:0]       d_imm;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_data;
  logic [ADDR_W:0]   d_count;

  // Small-capacity instance (DEPTH=4, ADDR_W=2)
  logic                c_clear, c_valid, c_ready, c_fmt, c_we, c_ack, c_full;
  logic [6:0]          c_funct7;
  logic [2:0]          c_funct3;
  logic [4:0]          c_rd, c_rs1, c_rs2;
  logic [11:0]         c_imm;
  logic [C_ADDR_W-1:0] c_addr;
  logic [31:0]         c_data;
  logic [C_ADDR_W:0]   c_count;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .clear_i(d_clear),
    .req_valid_i(d_valid), .req_ready_o(d_ready),
    .fmt_i(d_fmt), .funct7_i(d_funct7), .funct3_i(d_funct3),
    .rd_i(d_rd), .rs1_i(d_rs1), .rs2_i(d_rs2), .imm_i(d_imm),
    .mem_we_o(d_we), .mem_addr_o(d_addr), .mem_data_o(d_data),
    .mem_ack_i(d_ack), .count_o(d_count), .full_o(d_full)
  );

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(C_ADDR_W)) u_cap (
    .clk_i(clk), .rst_i(rst_n), .clear_i(c_clear),
    .req_valid_i(c_valid), .req_ready_o(c_ready),
    .fmt_i(c_fmt), .funct7_i(c_funct7), .funct3_i(c_funct3),
    .rd_i(c_rd), .rs1_i(c_rs1), .rs2_i(c_rs2), .imm_i(c_imm),
    .mem_we_o(c_we), .mem_addr_o(c_addr), .mem_data_o(c_data),
    .mem_ack_i(c_ack), .count_o(c_count), .full_o(c_full)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model of the main instance: words waiting for memory, and the
  // number of words already written.
  logic [31:0] m_q[$];
  int          m_count;

  function automatic logic [31:0] enc(input logic fmt, input logic [6:0] f7,
                                      input logic [2:0] f3, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [11:0] imm);
    if (fmt) return {imm, rs1, f3, rd, 7'b0010011};
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic bit m_ready();
    return !d_clear && (m_q.size() < DEPTH) && ((m_count + m_q.size()) < CAP);
  endfunction

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_edge();
    bit acc, pop;
    acc = d_valid && m_ready();
    pop = (m_q.size() != 0) && d_ack && !d_clear;
    if (d_clear) begin
      m_q.delete();
      m_count = 0;
    end else begin
      if (pop) begin
        void'(m_q.pop_front());
        m_count++;
      end
      if (acc) m_q.push_back(enc(d_fmt, d_funct7, d_funct3, d_rd, d_rs1, d_rs2, d_imm));
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_count = 0;
  endtask

  task automatic rand_fields();
    d_fmt    = 1'($urandom);
    d_funct7 = 7'($urandom);
    d_funct3 = 3'($urandom);
    d_rd     = 5'($urandom);
    d_rs1    = 5'($urandom);
    d_rs2    = 5'($urandom);
    d_imm    = 12'($urandom);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #2;
    checks++; if (d_we !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", d_we); end
    checks++; if (d_addr !== '0) begin failures++; $display("FAIL reset_addr: got %h want 0", d_addr); end
    checks++; if (d_count !== '0) begin failures++; $display("FAIL reset_count: got %0d want 0", d_count); end
    checks++; if (d_full !== 1'b0) begin failures++; $display("FAIL reset_full: got %b want 0", d_full); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    checks++; if (d_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b want 1", d_ready); end
    checks++; if (c_ready !== 1'b1) begin failures++; $display("FAIL reset_cap_ready: got %b want 1", c_ready); end
    @(negedge clk);
  endtask

  task automatic test_r_encode();
    d_valid = 1'b1; d_fmt = 1'b0; d_funct7 = 7'b0100000; d_rs2 = 5'd3; d_rs1 = 5'd2;
    d_funct3 = 3'b000; d_rd = 5'd1; d_ack = 1'b1;
    #1;
    checks++; if (d_ready !== 1'b1) begin failures++; $display("FAIL r_ready: got %b want 1", d_ready); end
    model_edge();
    @(negedge clk);
    d_valid = 1'b0;
    #1;
    checks++; if (d_we !== 1'b1) begin failures++; $display("FAIL r_we: got %b want 1", d_we); end
    checks++; if (d_data !== 32'h403100B3) begin failures++; $display("FAIL r_data: got %h want 403100b3", d_data); end
    checks++; if (d_addr !== 8'd0) begin failures++; $display("FAIL r_addr: got %h want 0", d_addr); end
    model_edge();
    @(negedge clk);
    #1;
    checks++; if (d_count !== 9'd1) begin failures++; $display("FAIL r_count: got %0d want 1", d_count); end
    checks++; if (d_we !== 1'b0) begin failures++; $display("FAIL r_we_after: got %b want 0", d_we); end
    @(negedge clk);
  endtask

  task automatic test_i_encode();
    d_valid = 1'b1; d_fmt = 1'b1; d_imm = 12'hFFF; d_rs1 = 5'd0; d_funct3 = 3'b000;
    d_rd = 5'd5; d_ack = 1'b1;
    #1;
    model_edge();
    @(negedge clk);
    d_valid = 1'b0;
    #1;
    checks++; if (d_data !== 32'hFFF00293) begin failures++; $display("FAIL i_data: got %h want fff00293", d_data); end
    checks++; if (d_addr !== 8'd1) begin failures++; $display("FAIL i_addr: got %h want 1", d_addr); end
    model_edge();
    @(negedge clk);
    #1;
    checks++; if (d_count !== 9'd2) begin failures++; $display("FAIL i_count: got %0d want 2", d_count); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int acc, commits;
    bit need_new, rdy, done;
    logic [31:0]       s_data;
    logic [ADDR_W-1:0] s_addr;
    // Flush first; ready must be low during the clear cycle.
    d_clear = 1'b1; d_valid = 1'b1; rand_fields();
    #1;
    checks++; if (d_ready !== 1'b0) begin failures++; $display("FAIL clear_ready: got %b want 0", d_ready); end
    model_edge();
    @(negedge clk);
    d_clear = 1'b0; d_ack = 1'b0;
    acc = 0; need_new = 1'b1; s_data = '0; s_addr = '0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      d_valid = 1'b1;
      if (need_new) rand_fields();
      #1;
      rdy = d_ready;
      if (rdy) acc++;
      need_new = rdy;
      if (cyc >= 1) begin
        checks++; if (d_we !== 1'b1) begin failures++; $display("FAIL bp_we c%0d: got %b want 1", cyc, d_we); end
      end
      if (cyc == 1) begin
        s_data = d_data; s_addr = d_addr;
        checks++; if (d_data !== m_q[0]) begin failures++; $display("FAIL bp_head: got %h want %h", d_data, m_q[0]); end
      end else if (cyc > 1) begin
        checks++; if (d_data !== s_data || d_addr !== s_addr) begin
          failures++; $display("FAIL bp_stable c%0d: got %h@%h want %h@%h", cyc, d_data, d_addr, s_data, s_addr);
        end
      end
      model_edge();
      @(negedge clk);
    end
    #1;
    checks++; if (acc != 4) begin failures++; $display("FAIL bp_accepts: got %0d want 4", acc); end
    checks++; if (d_ready !== 1'b0) begin failures++; $display("FAIL bp_ready: got %b want 0", d_ready); end
    checks++; if (d_count !== 9'd0) begin failures++; $display("FAIL bp_count: got %0d want 0", d_count); end
    // Release the memory and drain, offering the two remaining requests.
    d_ack = 1'b1; commits = 0; done = 1'b0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      if (need_new && acc < 6) rand_fields();
      d_valid = (acc < 6);
      #1;
      checks++; if (d_ready !== m_ready()) begin failures++; $display("FAIL bp_drain_ready c%0d: got %b want %b", cyc, d_ready, m_ready()); end
      checks++; if (d_we !== (m_q.size() != 0)) begin failures++; $display("FAIL bp_drain_we c%0d: got %b want %b", cyc, d_we, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        checks++; if (d_data !== m_q[0]) begin failures++; $display("FAIL bp_drain_data c%0d: got %h want %h", cyc, d_data, m_q[0]); end
        checks++; if (d_addr !== 8'(commits)) begin failures++; $display("FAIL bp_drain_addr c%0d: got %0d want %0d", cyc, d_addr, commits); end
        commits++;
      end
      need_new = d_valid && d_ready;
      if (need_new) acc++;
      model_edge();
      @(negedge clk);
      done = (acc == 6) && (commits == 6);
    end
    d_valid = 1'b0;
    #1;
    checks++; if (!done) begin failures++; $display("FAIL bp_timeout: accepts %0d commits %0d want 6/6", acc, commits); end
    checks++; if (d_count !== 9'd6) begin failures++; $display("FAIL bp_final_count: got %0d want 6", d_count); end
    @(negedge clk);
  endtask

  task automatic test_clear_mid();
    d_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d_valid = 1'b1; rand_fields();
      #1;
      checks++; if (d_ready !== 1'b1) begin failures++; $display("FAIL clr_fill_ready %0d: got %b want 1", i, d_ready); end
      model_edge();
      @(negedge clk);
    end
    d_clear = 1'b1; d_ack = 1'b1; d_valid = 1'b1; rand_fields();
    #1;
    checks++; if (d_ready !== 1'b0) begin failures++; $display("FAIL clr_ready: got %b want 0", d_ready); end
    checks++; if (d_we !== 1'b1) begin failures++; $display("FAIL clr_we_before: got %b want 1", d_we); end
    model_edge();
    @(negedge clk);
    d_clear = 1'b0; d_valid = 1'b0;
    #1;
    checks++; if (d_count !== 9'd0) begin failures++; $display("FAIL clr_count: got %0d want 0", d_count); end
    checks++; if (d_we !== 1'b0) begin failures++; $display("FAIL clr_we_after: got %b want 0", d_we); end
    checks++; if (d_addr !== 8'd0) begin failures++; $display("FAIL clr_addr: got %0d want 0", d_addr); end
    model_edge();
    @(negedge clk);
    d_valid = 1'b1; rand_fields();
    #1;
    model_edge();
    @(negedge clk);
    d_valid = 1'b0;
    #1;
    checks++; if (d_we !== 1'b1 || d_addr !== 8'd0 || d_data !== m_q[0]) begin
      failures++; $display("FAIL clr_next_write: got we=%b %h@%0d want we=1 %h@0", d_we, d_data, d_addr, m_q[0]);
    end
    model_edge();
    @(negedge clk);
    #1;
    checks++; if (d_count !== 9'd1) begin failures++; $display("FAIL clr_next_count: got %0d want 1", d_count); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    d_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d_valid = 1'b1; rand_fields();
      #1;
      model_edge();
      @(negedge clk);
    end
    d_valid = 1'b0;
    #1;
    checks++; if (d_we !== 1'b1 || d_count !== 9'd1) begin
      failures++; $display("FAIL rstm_pre: got we=%b count=%0d want we=1 count=1", d_we, d_count);
    end
    // Assert reset between clock edges; outputs must respond without an edge.
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    checks++; if (d_we !== 1'b0) begin failures++; $display("FAIL rstm_we: got %b want 0", d_we); end
    checks++; if (d_addr !== 8'd0) begin failures++; $display("FAIL rstm_addr: got %0d want 0", d_addr); end
    checks++; if (d_count !== 9'd0) begin failures++; $display("FAIL rstm_count: got %0d want 0", d_count); end
    checks++; if (d_full !== 1'b0) begin failures++; $display("FAIL rstm_full: got %b want 0", d_full); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (d_ready !== 1'b1) begin failures++; $display("FAIL rstm_ready: got %b want 1", d_ready); end
    @(negedge clk);
    #1;
    checks++; if (d_we !== 1'b0) begin failures++; $display("FAIL rstm_we_later: got %b want 0", d_we); end
    @(negedge clk);
  endtask

  task automatic test_capacity();
    logic [31:0] cq[$];
    int cnt, writes, accepts;
    bit exp_ready, exp_we, need_new;
    cnt = 0; writes = 0; accepts = 0; need_new = 1'b1;
    c_valid = 1'b1; c_ack = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (need_new) begin
        c_fmt = 1'($urandom); c_funct7 = 7'($urandom); c_funct3 = 3'($urandom);
        c_rd = 5'($urandom); c_rs1 = 5'($urandom); c_rs2 = 5'($urandom); c_imm = 12'($urandom);
      end
      #1;
      exp_ready = (cq.size() < DEPTH) && ((cnt + cq.size()) < C_CAP);
      exp_we    = (cq.size() != 0);
      checks++; if (c_ready !== exp_ready) begin failures++; $display("FAIL cap_ready c%0d: got %b want %b", cyc, c_ready, exp_ready); end
      checks++; if (c_we !== exp_we) begin failures++; $display("FAIL cap_we c%0d: got %b want %b", cyc, c_we, exp_we); end
      if (c_we === 1'b1) writes++;
      if (exp_we) begin
        checks++; if (c_addr !== 2'(cnt) || c_data !== cq[0]) begin
          failures++; $display("FAIL cap_write c%0d: got %h@%0d want %h@%0d", cyc, c_data, c_addr, cq[0], cnt);
        end
        void'(cq.pop_front());
        cnt++;
      end
      if (exp_ready) begin
        cq.push_back(enc(c_fmt, c_funct7, c_funct3, c_rd, c_rs1, c_rs2, c_imm));
        accepts++;
      end
      need_new = exp_ready;
      @(negedge clk);
    end
    c_valid = 1'b0; c_ack = 1'b0;
    #1;
    checks++; if (writes != 4) begin failures++; $display("FAIL cap_writes: got %0d want 4", writes); end
    checks++; if (accepts != 4) begin failures++; $display("FAIL cap_accepts: got %0d want 4", accepts); end
    checks++; if (c_count !== 3'd4) begin failures++; $display("FAIL cap_count: got %0d want 4", c_count); end
    checks++; if (c_full !== 1'b1) begin failures++; $display("FAIL cap_full: got %b want 1", c_full); end
    checks++; if (c_ready !== 1'b0) begin failures++; $display("FAIL cap_ready_end: got %b want 0", c_ready); end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      d_clear = ($urandom_range(0, 49) == 0);
      d_valid = ($urandom_range(0, 3) != 0);
      d_ack   = ($urandom_range(0, 2) != 0);
      rand_fields();
      #1;
      checks++; if (d_ready !== m_ready()) begin failures++; $display("FAIL rnd_ready c%0d: got %b want %b", cyc, d_ready, m_ready()); end
      checks++; if (d_we !== (m_q.size() != 0)) begin failures++; $display("FAIL rnd_we c%0d: got %b want %b", cyc, d_we, m_q.size() != 0); end
      checks++; if (d_count !== 9'(m_count) || d_full !== (m_count == CAP)) begin
        failures++; $display("FAIL rnd_count c%0d: got %0d/%b want %0d/%b", cyc, d_count, d_full, m_count, m_count == CAP);
      end
      if (m_q.size() != 0) begin
        checks++; if (d_data !== m_q[0] || d_addr !== 8'(m_count)) begin
          failures++; $display("FAIL rnd_write c%0d: got %h@%0d want %h@%0d", cyc, d_data, d_addr, m_q[0], m_count);
        end
      end
      model_edge();
      @(negedge clk);
    end
    d_clear = 1'b0; d_valid = 1'b0; d_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    d_clear = 1'b0; d_valid = 1'b0; d_ack = 1'b0;
    d_fmt = 1'b0; d_funct7 = '0; d_funct3 = '0; d_rd = '0; d_rs1 = '0; d_rs2 = '0; d_imm = '0;
    c_clear = 1'b0; c_valid = 1'b0; c_ack = 1'b0;
    c_fmt = 1'b0; c_funct7 = '0; c_funct3 = '0; c_rd = '0; c_rs1 = '0; c_rs2 = '0; c_imm = '0;
    model_reset();
    test_reset();
    test_r_encode();
    test_i_encode();
    test_backpressure();
    test_clear_mid();
    test_reset_mid();
    test_capacity();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
